// File: rtl/snn_pkg.sv
// Shared constants and types for the spike row packer.
// Row words, FSM states and a row popcount helper.
package snn_pkg;
  localparam int DEPTH_C    = 441;
  localparam int ADDR_C     = 9;
  localparam int ROW_W      = 21;
  localparam int ROW_ADDR_W = 5;
  localparam int NUM_TS     = 2;
  localparam int TS_W       = 2;
  localparam int ROWS       = DEPTH_C / ROW_W;
  localparam int COL_W      = $clog2(ROW_W);
  localparam int POP_W      = $clog2(ROW_W + 1);

  typedef logic [ROW_W-1:0] row_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TS,
    COLLECT,
    DRAIN
  } packer_state_t;

  function automatic logic [POP_W-1:0] popcnt(row_t r);
    logic [POP_W-1:0] s;
    s = '0;
    for (int i = 0; i < ROW_W; i++)
      s = s + {{(POP_W-1){1'b0}}, r[i]};
    return s;
  endfunction
endpackage

// File: rtl/spike_row_out_reg.sv
// One-entry valid/ready output register.
// Holds its payload stable while the consumer stalls.
module spike_row_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_data
);
  assign in_rdy = !out_vld || out_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_data <= '0;
    end else if (clr) begin
      out_vld  <= 1'b0;
      out_data <= '0;
    end else if (in_vld && in_rdy) begin
      out_vld  <= 1'b1;
      out_data <= in_data;
    end else if (out_rdy) begin
      out_vld  <= 1'b0;
    end
  end
endmodule

// File: rtl/spike_row_packer.sv
// Packs the serial spike stream into 21-bit row words.
// SPIKE_ROW_PACKER_POPCNT_EN adds row_pop_o and ts_pop_o.
module spike_row_packer
  import snn_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  ts_vld_i,
  input  logic [TS_W-1:0]       ts_i,
  input  logic                  spike_vld_i,
  output logic                  spike_rdy_o,
  input  logic [ADDR_C-1:0]     spike_addr_i,
  input  logic                  spike_i,
  input  logic                  done_i,
  output logic                  row_vld_o,
  input  logic                  row_rdy_i,
  output logic [ROW_W-1:0]      row_data_o,
  output logic [ROW_ADDR_W-1:0] row_idx_o,
  output logic [TS_W-1:0]       row_ts_o,
  output logic                  layer_done_o,
  output logic                  err_o
`ifdef SPIKE_ROW_PACKER_POPCNT_EN
  ,
  output logic [POP_W-1:0]      row_pop_o,
  output logic [ADDR_C:0]       ts_pop_o
`endif
);
`ifdef SPIKE_ROW_PACKER_POPCNT_EN
  localparam int PW = ROW_ADDR_W + TS_W + ROW_W + POP_W;
`else
  localparam int PW = ROW_ADDR_W + TS_W + ROW_W;
`endif

  packer_state_t state, nxt;

  logic [ADDR_C-1:0]     addr_ctr;
  logic [COL_W-1:0]      col;
  logic [ROW_ADDR_W-1:0] row_ctr;
  row_t                  asm_q;
  row_t                  row_next;
  row_t                  push_row;
  logic                  asm_full;
  logic [TS_W-1:0]       ts_q;
  logic [TS_W-1:0]       asm_ts;
  logic [TS_W-1:0]       push_ts;
  logic                  done_seen;
  logic                  accept;
  logic                  last_spk;
  logic                  row_done;
  logic                  push_vld;
  logic                  push_rdy;
  logic                  push;
  logic [PW-1:0]         push_data;
  logic [PW-1:0]         out_data;

  assign accept   = spike_vld_i && spike_rdy_o;
  assign last_spk = addr_ctr == ADDR_C'(DEPTH_C - 1);
  assign row_done = accept && (col == COL_W'(ROW_W - 1));

  always_comb begin
    row_next      = asm_q;
    row_next[col] = spike_i;
  end

  // A finished row bypasses the assembly reg when the output reg is free.
  assign push_vld = asm_full || row_done;
  assign push_row = asm_full ? asm_q : row_next;
  assign push_ts  = asm_full ? asm_ts : ts_q;
  assign push     = push_vld && push_rdy;

`ifdef SPIKE_ROW_PACKER_POPCNT_EN
  assign push_data = {row_ctr, push_ts, push_row, popcnt(push_row)};
  assign {row_idx_o, row_ts_o, row_data_o, row_pop_o} = out_data;
`else
  assign push_data = {row_ctr, push_ts, push_row};
  assign {row_idx_o, row_ts_o, row_data_o} = out_data;
`endif

  spike_row_out_reg #(.W(PW)) u_out (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (start_i),
    .in_vld   (push_vld),
    .in_rdy   (push_rdy),
    .in_data  (push_data),
    .out_vld  (row_vld_o),
    .out_rdy  (row_rdy_i),
    .out_data (out_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (start_i) begin
      nxt = WAIT_TS;
    end else begin
      unique case (state)
        IDLE:    nxt = IDLE;
        WAIT_TS: if (ts_vld_i) nxt = COLLECT;
        COLLECT: if (accept && last_spk)
                   nxt = (ts_q < TS_W'(NUM_TS)) ? WAIT_TS : DRAIN;
        DRAIN:   if (layer_done_o) nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    spike_rdy_o  = (state == COLLECT) && !asm_full;
    layer_done_o = (state == DRAIN) && !start_i && !asm_full
                   && !row_vld_o && (done_seen || done_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_ctr  <= '0;
      col       <= '0;
      row_ctr   <= '0;
      asm_q     <= '0;
      asm_full  <= 1'b0;
      ts_q      <= '0;
      asm_ts    <= '0;
      done_seen <= 1'b0;
      err_o     <= 1'b0;
    end else if (start_i) begin
      addr_ctr  <= '0;
      col       <= '0;
      row_ctr   <= '0;
      asm_q     <= '0;
      asm_full  <= 1'b0;
      ts_q      <= '0;
      asm_ts    <= '0;
      done_seen <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      if (state == WAIT_TS && ts_vld_i) begin
        ts_q     <= ts_i;
        addr_ctr <= '0;
        col      <= '0;
        if (ts_i == '0 || ts_i > TS_W'(NUM_TS)) err_o <= 1'b1;
      end
      if (ts_vld_i && state != WAIT_TS) err_o <= 1'b1;
      if (accept) begin
        addr_ctr <= last_spk ? '0 : addr_ctr + 1'b1;
        col      <= (col == COL_W'(ROW_W - 1)) ? '0 : col + 1'b1;
        if (spike_addr_i != addr_ctr) err_o <= 1'b1;
      end
      if (push) begin
        asm_q    <= '0;
        asm_full <= 1'b0;
        row_ctr  <= (row_ctr == ROW_ADDR_W'(ROWS - 1)) ? '0 : row_ctr + 1'b1;
      end else if (row_done) begin
        asm_q    <= row_next;
        asm_full <= 1'b1;
        asm_ts   <= ts_q;
      end else if (accept) begin
        asm_q    <= row_next;
      end
      if (layer_done_o)                     done_seen <= 1'b0;
      else if (done_i && state != IDLE)     done_seen <= 1'b1;
    end
  end

`ifdef SPIKE_ROW_PACKER_POPCNT_EN
  logic [ADDR_C:0] pop_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_acc  <= '0;
      ts_pop_o <= '0;
    end else if (start_i) begin
      pop_acc  <= '0;
      ts_pop_o <= '0;
    end else if (row_vld_o && row_rdy_i) begin
      if (row_idx_o == ROW_ADDR_W'(ROWS - 1)) begin
        ts_pop_o <= pop_acc + (ADDR_C+1)'(row_pop_o);
        pop_acc  <= '0;
      end else begin
        pop_acc  <= pop_acc + (ADDR_C+1)'(row_pop_o);
      end
    end
  end
`endif
endmodule

// File: tb/tb_spike_row_packer.sv
// Directed bench for spike_row_packer.
// Rows are captured on handshake and checked against a pattern model.
module tb_spike_row_packer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic        ts_vld_i;
  logic [1:0]  ts_i;
  logic        spike_vld_i;
  logic        spike_rdy_o;
  logic [8:0]  spike_addr_i;
  logic        spike_i;
  logic        done_i;
  logic        row_vld_o;
  logic        row_rdy_i;
  logic [20:0] row_data_o;
  logic [4:0]  row_idx_o;
  logic [1:0]  row_ts_o;
  logic        layer_done_o;
  logic        err_o;
`ifdef SPIKE_ROW_PACKER_POPCNT_EN
  logic [4:0]  row_pop_o;
  logic [9:0]  ts_pop_o;
`endif

  spike_row_packer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .ts_vld_i     (ts_vld_i),
    .ts_i         (ts_i),
    .spike_vld_i  (spike_vld_i),
    .spike_rdy_o  (spike_rdy_o),
    .spike_addr_i (spike_addr_i),
    .spike_i      (spike_i),
    .done_i       (done_i),
    .row_vld_o    (row_vld_o),
    .row_rdy_i    (row_rdy_i),
    .row_data_o   (row_data_o),
    .row_idx_o    (row_idx_o),
    .row_ts_o     (row_ts_o),
    .layer_done_o (layer_done_o),
    .err_o        (err_o)
`ifdef SPIKE_ROW_PACKER_POPCNT_EN
    ,
    .row_pop_o    (row_pop_o),
    .ts_pop_o     (ts_pop_o)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int ld_cnt = 0;
  int ld_cyc = 0;
  int hs_cyc = 0;
  int sent = 0;
  logic [27:0] q[$];

  always @(posedge clk) begin
    cyc++;
    if (rst_n && row_vld_o && row_rdy_i) begin
      q.push_back({row_idx_o, row_ts_o, row_data_o});
      hs_cyc = cyc;
    end
    if (layer_done_o) begin
      ld_cnt++;
      ld_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit pat_bit(input int p, input int a);
    case (p)
      0: return 1'b1;
      1: return (a == 0 || a == 20 || a == 21);
      3: return (a % 7 == 3);
      4: return (a == 4);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [20:0] exp_row(input int p, input int r);
    logic [20:0] e;
    for (int k = 0; k < 21; k++) e[k] = pat_bit(p, r * 21 + k);
    return e;
  endfunction

  task automatic do_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic do_ts(input logic [1:0] t);
    ts_vld_i = 1'b1;
    ts_i     = t;
    @(negedge clk);
    ts_vld_i = 1'b0;
  endtask

  task automatic send(input int a, input bit b);
    int n;
    spike_addr_i = 9'(a);
    spike_i      = b;
    spike_vld_i  = 1'b1;
    n = 0;
    while (!spike_rdy_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      n_cmp++;
      n_err++;
      $error("FAIL spike_timeout: observed stalled expected accepted addr %0d", a);
    end
    @(negedge clk);
    sent++;
  endtask

  task automatic send_ts(input int p, input int bad, input int from,
                         input int to);
    for (int i = from; i < to; i++)
      send((i == bad) ? i + 1 : i, pat_bit(p, i));
    spike_vld_i = 1'b0;
  endtask

  task automatic check_ts(input int p, input logic [1:0] t);
    int n;
    logic [27:0] e;
    n = 0;
    while (q.size() < 21 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("row_count", q.size(), 21);
    for (int r = 0; r < 21; r++) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("row", e, {5'(r), t, exp_row(p, r)});
      end
    end
  endtask

  task automatic end_layer();
    int b;
    int n;
    b = ld_cnt;
    done_i = 1'b1;
    @(negedge clk);
    done_i = 1'b0;
    n = 0;
    while (ld_cnt == b && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("layer_done", ld_cnt, b + 1);
  endtask

  task automatic full_layer(input int p);
    do_start();
    chk("wait_ts_rdy", spike_rdy_o, 0);
    do_ts(2'd1);
    send_ts(p, -1, 0, 441);
    check_ts(p, 2'd1);
    do_ts(2'd2);
    send_ts(p, -1, 0, 441);
    check_ts(p, 2'd2);
    end_layer();
  endtask

  initial begin
    int b;
    rst_n        = 1'b0;
    start_i      = 1'b0;
    ts_vld_i     = 1'b0;
    ts_i         = '0;
    spike_vld_i  = 1'b0;
    spike_addr_i = '0;
    spike_i      = 1'b0;
    done_i       = 1'b0;
    row_rdy_i    = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_row_vld", row_vld_o, 0);
    chk("rst_spike_rdy", spike_rdy_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_done", layer_done_o, 0);
    chk("rst_data", row_data_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    full_layer(0);
`ifdef SPIKE_ROW_PACKER_POPCNT_EN
    chk("ts_pop_all", ts_pop_o, 441);
`endif
    chk("err_clean", err_o, 0);

    full_layer(1);
`ifdef SPIKE_ROW_PACKER_POPCNT_EN
    chk("ts_pop_sparse", ts_pop_o, 3);
`endif

    do_start();
    do_ts(2'd1);
    row_rdy_i = 1'b0;
    sent = 0;
    fork
      begin
        repeat (50) @(negedge clk);
        chk("stall_rdy", spike_rdy_o, 0);
        chk("stall_sent", sent, 42);
        row_rdy_i = 1'b1;
      end
      send_ts(3, -1, 0, 441);
    join
    check_ts(3, 2'd1);
    do_ts(2'd2);
    send_ts(3, -1, 0, 441);
    check_ts(3, 2'd2);
    end_layer();

    do_start();
    do_ts(2'd1);
    send_ts(4, 4, 0, 441);
    chk("addr_err", err_o, 1);
    check_ts(4, 2'd1);
    do_ts(2'd2);
    send_ts(2, -1, 0, 441);
    check_ts(2, 2'd2);
    chk("err_sticky", err_o, 1);
    end_layer();
    do_start();
    chk("err_cleared", err_o, 0);
    do_ts(2'd3);
    chk("ts_range_err", err_o, 1);
    do_start();
    chk("err_cleared2", err_o, 0);

    do_ts(2'd1);
    send_ts(1, -1, 0, 441);
    check_ts(1, 2'd1);
    do_ts(2'd2);
    send_ts(1, -1, 0, 420);
    row_rdy_i = 1'b0;
    send_ts(1, -1, 420, 441);
    b = ld_cnt;
    done_i = 1'b1;
    @(negedge clk);
    done_i = 1'b0;
    repeat (10) @(negedge clk);
    chk("early_done_held", ld_cnt, b);
    chk("early_rows", q.size(), 19);
    row_rdy_i = 1'b1;
    repeat (8) @(negedge clk);
    chk("done_pulse", ld_cnt, b + 1);
    chk("done_after_hs", 32'(ld_cyc > hs_cyc), 1);
    check_ts(1, 2'd2);

    do_start();
    do_ts(2'd1);
    send_ts(0, -1, 0, 441);
    check_ts(0, 2'd1);
    do_ts(2'd2);
    send_ts(0, -1, 0, 200);
    rst_n = 1'b0;
    #1;
    chk("arst_row_vld", row_vld_o, 0);
    chk("arst_spike_rdy", spike_rdy_o, 0);
    chk("arst_idx", row_idx_o, 0);
    chk("arst_done", layer_done_o, 0);
    @(negedge clk);
    q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    full_layer(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
